// File: rtl/fast_fir_2par.sv
// Purpose : 2-parallel fast FIR (three TAPS/2 subfilters H0, H1, H0+H1) with
//           double-buffered coefficients, round/truncate, saturate/wrap.
// Latency : 2 cycles, in_valid at t -> out_valid at t+2. No backpressure:
//           one sample pair accepted per in_valid cycle, idle cycles hold state.
// Ports   : clk, rst_n (sync, active-low); in_valid/din0/din1 = x(2k), x(2k+1);
//           coef_we/coef_addr/coef_wdata write shadow bank; coef_commit copies
//           shadow -> active; round_en/sat_en output-stage controls;
//           out_valid/dout0/dout1 = y(2k), y(2k+1); ovf = sticky overflow.
module fast_fir_2par #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int TAPS   = 102,
  parameter int ACC_W  = 64,
  parameter int SHIFT  = 31,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        din0,
  input  logic [DATA_W-1:0]        din1,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     coef_commit,
  input  logic                     round_en,
  input  logic                     sat_en,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         dout0,
  output logic [OUT_W-1:0]         dout1,
  output logic                     ovf
);

  localparam int L       = TAPS / 2;
  localparam int PW      = DATA_W + COEF_W + 2;  // pre-added sample x pre-added coef
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND_INC = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;

  // Sign-extend both operands to the full product width, then multiply.
  function automatic logic [PW-1:0] mul_ext(input logic [DATA_W:0] x, input logic [COEF_W:0] c);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ce;
    xe = {{(PW-DATA_W-1){x[DATA_W]}}, x};
    ce = {{(PW-COEF_W-1){c[COEF_W]}}, c};
    return xe * ce;
  endfunction

  function automatic logic [ACC_W-1:0] acc_ext(input logic [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  // Returns {overflow, result}. One guard bit above ACC_W keeps the rounding
  // increment from wrapping at the positive extreme.
  function automatic logic [OUT_W:0] scale(input logic [ACC_W-1:0] a, input logic rnd, input logic sat);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] v;
    logic                  fits;
    logic [OUT_W-1:0]      q;
    t = {a[ACC_W-1], a};
    if (rnd) t = t + RND_INC;
    v = t >>> SHIFT;
    fits = (&v[ACC_W:OUT_W-1]) | (~|v[ACC_W:OUT_W-1]);
    q = v[OUT_W-1:0];
    if (!fits && sat) q = v[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return {~fits, q};
  endfunction

  logic [COEF_W-1:0] shadow_q [TAPS];
  logic [COEF_W-1:0] shadow_d [TAPS];
  logic [COEF_W-1:0] active_q [TAPS];
  logic [COEF_W-1:0] active_d [TAPS];
  logic [DATA_W-1:0] x0_q [L-1];
  logic [DATA_W-1:0] x0_d [L-1];
  logic [DATA_W-1:0] x1_q [L-1];
  logic [DATA_W-1:0] x1_d [L-1];
  logic [DATA_W-1:0] xa_tap [L];
  logic [DATA_W-1:0] xb_tap [L];
  logic [ACC_W-1:0]  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, z1_q, z1_d;
  logic              v1_q, v1_d;
  logic              out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [OUT_W-1:0]  dout0_q, dout0_d, dout1_q, dout1_d;
  logic [ACC_W-1:0]  h0x0, h1x1, h01x01, y0, y1;
  logic [OUT_W:0]    r0, r1;

  // Write lands in shadow first so a same-cycle commit picks it up.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (coef_we && (int'(coef_addr) < TAPS)) shadow_d[coef_addr] = coef_wdata;
    if (coef_commit) active_d = shadow_d;
  end

  always_comb begin
    x0_d = x0_q;
    x1_d = x1_q;
    if (in_valid) begin
      x0_d[0] = din0;
      x1_d[0] = din1;
      for (int j = 1; j < L-1; j++) begin
        x0_d[j] = x0_q[j-1];
        x1_d[j] = x1_q[j-1];
      end
    end
  end

  // Tap 0 is the current input pair; older taps come from the delay lines.
  always_comb begin
    xa_tap[0] = din0;
    xb_tap[0] = din1;
    for (int j = 1; j < L; j++) begin
      xa_tap[j] = x0_q[j-1];
      xb_tap[j] = x1_q[j-1];
    end
  end

  // Subfilters run in the accept cycle against the active bank as it stands,
  // so a pair accepted alongside a commit still sees the old coefficients.
  always_comb begin
    logic [DATA_W:0] xa_e, xb_e, xs;
    logic [COEF_W:0] ca, cb, cs;
    xa_e = '0; xb_e = '0; xs = '0; ca = '0; cb = '0; cs = '0;
    h0x0 = '0; h1x1 = '0; h01x01 = '0;
    for (int j = 0; j < L; j++) begin
      xa_e = {xa_tap[j][DATA_W-1], xa_tap[j]};
      xb_e = {xb_tap[j][DATA_W-1], xb_tap[j]};
      xs   = xa_e + xb_e;
      ca   = {active_q[2*j][COEF_W-1], active_q[2*j]};
      cb   = {active_q[2*j+1][COEF_W-1], active_q[2*j+1]};
      cs   = ca + cb;
      h0x0   = h0x0   + acc_ext(mul_ext(xa_e, ca));
      h1x1   = h1x1   + acc_ext(mul_ext(xb_e, cb));
      h01x01 = h01x01 + acc_ext(mul_ext(xs, cs));
    end
    v1_d = in_valid;
    s0_d = in_valid ? h0x0   : s0_q;
    s1_d = in_valid ? h1x1   : s1_q;
    s2_d = in_valid ? h01x01 : s2_q;
    // z^-1 on H1X1: previous accepted pair's value, advanced only on accept.
    z1_d = in_valid ? s1_q   : z1_q;
  end

  always_comb begin
    y0 = s0_q + z1_q;
    y1 = s2_q - s0_q - s1_q;
    r0 = scale(y0, round_en, sat_en);
    r1 = scale(y1, round_en, sat_en);
    out_valid_d = v1_q;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    ovf_d       = ovf_q;
    if (v1_q) begin
      dout0_d = r0[OUT_W-1:0];
      dout1_d = r1[OUT_W-1:0];
      ovf_d   = ovf_q | r0[OUT_W] | r1[OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      x0_q        <= '{default: '0};
      x1_q        <= '{default: '0};
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      z1_q        <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      z1_q        <= z1_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fast_fir_2par.sv
// Purpose : directed check of fast_fir_2par; instance a has SHIFT=0/OUT_W=16,
//           instance b has SHIFT=1, both TAPS=8 and driven by shared inputs.
// Timing  : inputs change 1 time unit after posedge, outputs captured on negedge.
module tb_fast_fir_2par;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, coef_we, coef_commit, round_en, sat_en;
  logic [15:0] din0, din1;
  logic [2:0]  coef_addr;
  logic [31:0] coef_wdata;
  logic        a_out_valid, b_out_valid, a_ovf, b_ovf;
  logic signed [15:0] a_dout0, a_dout1, b_dout0, b_dout1;

  int n_chk = 0;
  int n_pass = 0;
  int qa0[$], qa1[$], qb0[$];
  int hv[8];
  int hg[8];
  int xg[16];
  int yexp[16];

  fast_fir_2par #(.DATA_W(16), .COEF_W(32), .TAPS(8), .ACC_W(64), .SHIFT(0), .OUT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din0(din0), .din1(din1),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .round_en(round_en), .sat_en(sat_en),
    .out_valid(a_out_valid), .dout0(a_dout0), .dout1(a_dout1), .ovf(a_ovf));

  fast_fir_2par #(.DATA_W(16), .COEF_W(32), .TAPS(8), .ACC_W(64), .SHIFT(1), .OUT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din0(din0), .din1(din1),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .round_en(round_en), .sat_en(sat_en),
    .out_valid(b_out_valid), .dout0(b_dout0), .dout1(b_dout1), .ovf(b_ovf));

  always @(negedge clk) begin
    if (a_out_valid) begin
      qa0.push_back(int'(a_dout0));
      qa1.push_back(int'(a_dout1));
    end
    if (b_out_valid) qb0.push_back(int'(b_dout0));
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -99999;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qa0.delete();
    qa1.delete();
    qb0.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
    din0 = '0; din1 = '0; coef_addr = '0; coef_wdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load(input int h[8]);
    for (int i = 0; i < 8; i++) begin
      coef_we = 1'b1; coef_addr = 3'(i); coef_wdata = 32'(h[i]);
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  task automatic send(input int a, input int b);
    in_valid = 1'b1; din0 = 16'(a); din1 = 16'(b);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic run_model(input bit gaps);
    int g;
    do_reset();
    load(hg);
    commit();
    clear_q();
    for (int k = 0; k < 8; k++) begin
      send(xg[2*k], xg[2*k+1]);
      if (gaps) begin
        g = $urandom_range(0, 5);
        if (g > 0) idle(g);
      end
    end
    idle(5);
    chk(gaps ? "gap_count" : "nogap_count", qa0.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_y%0d", gaps ? "gap" : "nogap", 2*k),   qat(qa0, k), yexp[2*k]);
      chk($sformatf("%s_y%0d", gaps ? "gap" : "nogap", 2*k+1), qat(qa1, k), yexp[2*k+1]);
    end
  endtask

  initial begin
    round_en = 1'b0;
    sat_en   = 1'b0;

    // Reset state
    do_reset();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_dout0", a_dout0, 0);
    chk("rst_dout1", a_dout1, 0);
    chk("rst_ovf", a_ovf, 0);

    // Impulse: h(n)=n+1 -> y = 1..8 in pair order, 2-cycle latency
    hv = '{1, 2, 3, 4, 5, 6, 7, 8};
    load(hv);
    commit();
    clear_q();
    send(1, 0);
    chk("lat_t1_valid", a_out_valid, 0);
    send(0, 0);
    chk("lat_t2_valid", a_out_valid, 1);
    chk("lat_t2_dout0", a_dout0, 1);
    send(0, 0);
    send(0, 0);
    idle(4);
    chk("imp_count", qa0.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("imp_dout0_%0d", k), qat(qa0, k), 2*k + 1);
      chk($sformatf("imp_dout1_%0d", k), qat(qa1, k), 2*k + 2);
    end
    chk("hold_dout0", a_dout0, 7);
    chk("hold_dout1", a_dout1, 8);

    // Commit ordering: pair in the commit cycle uses the old (zero) bank
    do_reset();
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 32'd5;
    tick();
    coef_we = 1'b0;
    clear_q();
    coef_commit = 1'b1; in_valid = 1'b1; din0 = 16'd1; din1 = 16'd0;
    tick();
    coef_commit = 1'b0;
    send(1, 0);
    idle(4);
    chk("cmt_count", qa0.size(), 2);
    chk("cmt_old_bank", qat(qa0, 0), 0);
    chk("cmt_new_bank", qat(qa0, 1), 5);

    // Write + commit in the same cycle; later shadow-only write is invisible
    do_reset();
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 32'd3; coef_commit = 1'b1;
    tick();
    coef_we = 1'b0; coef_commit = 1'b0;
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 32'd9;
    tick();
    coef_we = 1'b0;
    clear_q();
    send(1, 0);
    idle(4);
    chk("we_commit_same", qat(qa0, 0), 3);

    // Overflow with saturation, both directions
    do_reset();
    sat_en = 1'b1;
    hv = '{32767, 0, 0, 0, 0, 0, 0, 0};
    load(hv);
    commit();
    clear_q();
    send(2, 0);
    send(-2, 0);
    idle(4);
    chk("sat_pos", qat(qa0, 0), 32767);
    chk("sat_neg", qat(qa0, 1), -32768);
    chk("sat_dout1", qat(qa1, 0), 0);
    chk("sat_ovf", a_ovf, 1);

    // Overflow with wrap, ovf sticky
    do_reset();
    chk("ovf_cleared", a_ovf, 0);
    sat_en = 1'b0;
    load(hv);
    commit();
    clear_q();
    send(2, 0);
    idle(4);
    chk("wrap_dout0", qat(qa0, 0), -2);
    chk("wrap_ovf", a_ovf, 1);
    send(0, 0);
    idle(4);
    chk("ovf_sticky", a_ovf, 1);

    // Reset mid-stream with two pairs in flight
    clear_q();
    send(2, 0);
    rst_n = 1'b0; in_valid = 1'b1; din0 = 16'd2; din1 = 16'd0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_ovf", a_ovf, 0);
    idle(5);
    chk("midrst_no_out", qa0.size(), 0);
    send(5, 0);
    idle(4);
    chk("midrst_count", qa0.size(), 1);
    chk("midrst_zero", qat(qa0, 0), 0);
    chk("midrst_ovf_after", a_ovf, 0);

    // Rounding: SHIFT=1 on instance b; SHIFT=0 on instance a never rounds
    do_reset();
    hv = '{1, 0, 0, 0, 0, 0, 0, 0};
    load(hv);
    commit();
    round_en = 1'b0;
    clear_q();
    send(3, 0);
    send(-3, 0);
    idle(4);
    chk("trunc_pos", qat(qb0, 0), 1);
    chk("trunc_neg", qat(qb0, 1), -2);
    round_en = 1'b1;
    clear_q();
    send(3, 0);
    send(-3, 0);
    idle(4);
    chk("round_pos", qat(qb0, 0), 2);
    chk("round_neg", qat(qb0, 1), -1);
    chk("round_shift0_pos", qat(qa0, 0), 3);
    chk("round_shift0_neg", qat(qa0, 1), -3);
    round_en = 1'b0;

    // Gapless vs gapped streams against a direct-form convolution
    hg = '{3, -1, 4, 1, -5, 9, 2, -6};
    xg = '{5, -2, 7, 0, -3, 1, 4, -8, 2, 6, -1, 3, 0, -7, 2, 1};
    for (int m = 0; m < 16; m++) begin
      yexp[m] = 0;
      for (int n = 0; n < 8; n++)
        if (m - n >= 0) yexp[m] += hg[n] * xg[m-n];
    end
    run_model(1'b0);
    run_model(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
